// File: rtl/gemm_pkg.sv
// Shared types and default geometry for the GEMM tile scheduler.
package gemm_pkg;

  localparam int unsigned DefAddrWidth = 12;
  localparam int unsigned DefRowPar    = 4;
  localparam int unsigned DefColPar    = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/gemm_wrap_counter.sv
// Up-counter that wraps to zero after reaching limit_i; flags first and last counts.
module gemm_wrap_counter #(
  parameter int Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [Width-1:0] limit_i,
  output logic             first_o,
  output logic             last_o
);

  logic [Width-1:0] cnt_q;

  assign first_o = (cnt_q == '0);
  assign last_o  = (cnt_q == limit_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= last_o ? '0 : cnt_q + Width'(1);
    end
  end

endmodule

// File: rtl/gemm_tile_scheduler.sv
// Walks a tiled GEMM: one A/B word pair per cycle, k innermost, C tile written
// two cycles after the last k of each tile.
//
// state | meaning
// IDLE  | waiting for start_i, sizes sampled on the start edge
// RUN   | issuing A/B addresses, one per cycle
// DRAIN | two cycles to retire the last MAC and the last C write
// DONE  | one-cycle done_o (with err_o if the job was rejected)
module gemm_tile_scheduler
  import gemm_pkg::*;
#(
  parameter int AddrWidth     = DefAddrWidth,
  parameter int SizeAddrWidth = 32,
  parameter int RowPar        = DefRowPar,
  parameter int ColPar        = DefColPar
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [SizeAddrWidth-1:0] M_size_i,
  input  logic [SizeAddrWidth-1:0] K_size_i,
  input  logic [SizeAddrWidth-1:0] N_size_i,
  output logic [AddrWidth-1:0]     sram_a_addr_o,
  output logic [AddrWidth-1:0]     sram_b_addr_o,
  output logic [AddrWidth-1:0]     sram_c_addr_o,
  output logic                     sram_c_we_o,
  output logic                     mac_en_o,
  output logic                     acc_clear_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
);

  localparam int RowSh = $clog2(RowPar);
  localparam int ColSh = $clog2(ColPar);
  localparam logic [SizeAddrWidth-1:0] RowMask = SizeAddrWidth'(RowPar - 1);
  localparam logic [SizeAddrWidth-1:0] ColMask = SizeAddrWidth'(ColPar - 1);

  state_e state_q, state_d;

  logic [SizeAddrWidth-1:0] m_q, k_q, n_q;
  logic [SizeAddrWidth-1:0] k_lim, tn_lim, tm_lim;
  logic                     accept, size_bad, issue, issue_last, tile_end;
  logic                     k_first, k_last, tn_last, tm_last, tn_unused_first, tm_unused_first;
  logic                     drain_q, err_q;
  logic [AddrWidth-1:0]     a_addr_q, a_base_q, b_addr_q;
  logic [AddrWidth-1:0]     tile_idx_q, tile_d1_q, c_addr_q;
  logic                     mac_q, clr_q, tile_end_q, c_we_q;

  assign size_bad = (M_size_i == '0) || (K_size_i == '0) || (N_size_i == '0) ||
                    ((M_size_i & RowMask) != '0) || ((N_size_i & ColMask) != '0);
  assign accept     = (state_q == ST_IDLE) && start_i;
  assign issue      = (state_q == ST_RUN);
  assign tile_end   = issue && k_last;
  assign issue_last = tile_end && tn_last && tm_last;

  assign k_lim  = k_q - SizeAddrWidth'(1);
  assign tn_lim = (n_q >> ColSh) - SizeAddrWidth'(1);
  assign tm_lim = (m_q >> RowSh) - SizeAddrWidth'(1);

  gemm_wrap_counter #(.Width(SizeAddrWidth)) u_k_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (accept),
    .en_i    (issue),
    .limit_i (k_lim),
    .first_o (k_first),
    .last_o  (k_last)
  );

  gemm_wrap_counter #(.Width(SizeAddrWidth)) u_tn_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (accept),
    .en_i    (tile_end),
    .limit_i (tn_lim),
    .first_o (tn_unused_first),
    .last_o  (tn_last)
  );

  gemm_wrap_counter #(.Width(SizeAddrWidth)) u_tm_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (accept),
    .en_i    (tile_end && tn_last),
    .limit_i (tm_lim),
    .first_o (tm_unused_first),
    .last_o  (tm_last)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i) state_d = size_bad ? ST_DONE : ST_RUN;
      ST_RUN:   if (issue_last) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_q     <= '0;
      k_q     <= '0;
      n_q     <= '0;
      err_q   <= 1'b0;
      drain_q <= 1'b0;
    end else begin
      if (accept) begin
        m_q   <= M_size_i;
        k_q   <= K_size_i;
        n_q   <= N_size_i;
        err_q <= size_bad;
      end
      drain_q <= (state_q == ST_DRAIN) ? ~drain_q : 1'b0;
    end
  end

  // A walks tm*K+k and rewinds to the row base for each new tn; B walks tn*K+k
  // contiguously and restarts at 0 for each new tm.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_addr_q <= '0;
      a_base_q <= '0;
      b_addr_q <= '0;
    end else if (accept) begin
      a_addr_q <= '0;
      a_base_q <= '0;
      b_addr_q <= '0;
    end else if (issue && !issue_last) begin
      if (k_last && tn_last) begin
        a_addr_q <= a_addr_q + AddrWidth'(1);
        a_base_q <= a_addr_q + AddrWidth'(1);
        b_addr_q <= '0;
      end else if (k_last) begin
        a_addr_q <= a_base_q;
        b_addr_q <= b_addr_q + AddrWidth'(1);
      end else begin
        a_addr_q <= a_addr_q + AddrWidth'(1);
        b_addr_q <= b_addr_q + AddrWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mac_q      <= 1'b0;
      clr_q      <= 1'b0;
      tile_end_q <= 1'b0;
      c_we_q     <= 1'b0;
      tile_idx_q <= '0;
      tile_d1_q  <= '0;
      c_addr_q   <= '0;
    end else begin
      mac_q      <= issue;
      clr_q      <= issue && k_first;
      tile_end_q <= tile_end;
      c_we_q     <= tile_end_q;
      if (accept) begin
        tile_idx_q <= '0;
      end else if (tile_end) begin
        tile_idx_q <= tile_idx_q + AddrWidth'(1);
        tile_d1_q  <= tile_idx_q;
      end
      if (tile_end_q) c_addr_q <= tile_d1_q;
    end
  end

  assign sram_a_addr_o = a_addr_q;
  assign sram_b_addr_o = b_addr_q;
  assign sram_c_addr_o = c_addr_q;
  assign sram_c_we_o   = c_we_q;
  assign mac_en_o      = mac_q;
  assign acc_clear_o   = clr_q;
  assign busy_o        = (state_q != ST_IDLE);
  assign done_o        = (state_q == ST_DONE);
  assign err_o         = (state_q == ST_DONE) && err_q;

endmodule

// File: doc/gemm_tile_scheduler.md
GEMM_TILE_SCHEDULER -- requirements
Module: gemm_tile_scheduler

Interface
REQ-001 SHALL have parameter AddrWidth, default 12: SRAM address width.
REQ-002 SHALL have parameter SizeAddrWidth, default 32: width of the M/K/N size inputs.
REQ-003 SHALL have parameter RowPar, default 4: tile rows, i.e. A elements per word.
REQ-004 SHALL have parameter ColPar, default 16: tile columns, i.e. B elements per word.
REQ-005 SHALL have ports, in this order:
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  job request, sampled in IDLE only.
- M_size_i, K_size_i, N_size_i  in  SizeAddrWidth  matrix dimensions.
- sram_a_addr_o, sram_b_addr_o, sram_c_addr_o  out  AddrWidth  A, B and C word addresses.
- sram_c_we_o  out  1  C tile write strobe.
- mac_en_o  out  1  accumulator update enable; SRAM read data is valid in this cycle.
- acc_clear_o  out  1  with mac_en_o: load the product and discard the old sum (k==0).
- busy_o  out  1  job in progress.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  held with done_o when the job was rejected.

Function
REQ-006 SHALL implement a state machine with states IDLE, RUN, DRAIN, DONE.
REQ-007 IDLE + start_i=1: SHALL latch the three sizes and compute Mt=M/RowPar and Nt=N/ColPar by shift; the divisions SHALL be shifts, so RowPar and ColPar must be powers of two.
REQ-008 On start, SHALL go to DONE with err_o=1 and issue no MAC or write if any size is 0, or M%RowPar!=0, or N%ColPar!=0; otherwise SHALL go to RUN.
REQ-009 RUN SHALL issue one A/B address pair per cycle, looping k innermost (0..K-1), then tn (0..Nt-1), then tm (0..Mt-1).
REQ-010 sram_a_addr_o SHALL equal tm*K+k and sram_b_addr_o SHALL equal tn*K+k.
REQ-011 Both addresses SHALL be formed from running base registers with additions only (no multiplier) and SHALL wrap modulo 2^AddrWidth.
REQ-012 Memories have 1-cycle read latency: mac_en_o SHALL be the RUN issue strobe delayed 1 cycle, and acc_clear_o SHALL be the k==0 issue flag delayed 1 cycle.
REQ-013 sram_c_we_o SHALL pulse 2 cycles after the k==K-1 issue of each tile.
REQ-014 During that pulse, sram_c_addr_o SHALL equal tm*Nt+tn of the finished tile; the C address SHALL hold its last value otherwise.
REQ-015 There SHALL be no bubble between tiles: the C write of tile i SHALL coincide with the acc_clear_o MAC of tile i+1.
REQ-016 After the final issue, the FSM SHALL go RUN->DRAIN for exactly 2 cycles, covering the last MAC and the last C write.
REQ-017 After DRAIN, the FSM SHALL go DONE->IDLE; done_o SHALL be high for exactly the DONE cycle.
REQ-018 busy_o SHALL be high in RUN, DRAIN and DONE.
REQ-019 start_i SHALL be ignored outside IDLE; size inputs SHALL be ignored after being latched.
REQ-020 K=1 SHALL give one issue per tile, with every mac_en_o also carrying acc_clear_o.
REQ-021 Total cycles from the start edge to done_o SHALL be Mt*Nt*K+3.
REQ-022 err_o SHALL clear on the next accepted start.

Reset
REQ-023 rst_i=1 SHALL force, asynchronously, state IDLE, all counters and base registers 0, and all outputs 0.
REQ-024 Reset mid-job SHALL abort without done_o, and any later C write SHALL be suppressed.
REQ-025 The first start after reset release SHALL behave as a fresh job.

Structure
REQ-026 A shared package gemm_pkg SHALL hold the state enum and the RowPar/ColPar/AddrWidth default constants.
REQ-027 A sub-module gemm_wrap_counter SHALL provide a counter with clear, enable, wrap limit and last flag, instantiated for k, tn and tm.

Verification
REQ-028 M=K=N=32: SHALL give 512 issues, 16 C writes at addresses 0..15, and done_o 515 cycles after start, with the results matching the golden GEMM.
REQ-029 M=4, K=64, N=16: SHALL give one tile, one C write at address 0, and done_o after 67 cycles.
REQ-030 M=8, K=1, N=32: SHALL give 4 tiles, every mac_en_o with acc_clear_o, and back-to-back C writes at addresses 0..3.
REQ-031 M=6 (or K=0): SHALL give done_o with err_o=1 at 1 cycle after start, and no mac_en_o or sram_c_we_o.
REQ-032 start_i pulsed in RUN plus size changes: SHALL produce no effect on the job or its cycle count.
REQ-033 rst_i asserted at cycle 100 of a 32^3 job: SHALL drop all outputs to 0 at once, with no done_o; a following 4x64x16 job SHALL pass.
